spi_shift_engine: RTL and testbench
===================================

Name: spi_shift_engine

Overview:
- Master-mode SPI serializer sitting directly downstream of the APB-side SPI register controller.
- Consumes SPICR_1, SPICR_2, SPIBDR and MWDATA from the controller, and drives the SPI pins.
- Returns SPISR and MRDATA to the controller for APB readback.
- Contains a single-entry transmit buffer, an internal baud generator running on PCLK, and the transfer FSM.

Parameters:
- DATA_W, 8: bits per transfer. Supported values are 8 and 16. MWDATA[DATA_W-1:0] is transmitted.

Ports:
- PCLK  in  1  system clock; all logic is clocked on its rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- SPICR_1  in  8  bit6 SPE, bit5 SPTIE, bit4 MSTR, bit3 CPOL, bit2 CPHA, bit1 SSOE, bit0 LSBFE.
- SPICR_2  in  8  bit0 SPC0 (ignored; pins always unidirectional).
- SPIBDR  in  8  bits[6:4] SPPR, bits[2:0] SPR.
- MWDATA  in  32  transmit word.
- tx_load  in  1  one-cycle pulse: MWDATA was written this cycle.
- status_rd  in  1  one-cycle pulse: SPISR was read; clears MODF.
- data_rd  in  1  one-cycle pulse: MRDATA was read; clears SPIF.
- MISO  in  1  serial input.
- SS_IN_n  in  1  mode-fault sense input, used only when SSOE=0.
- SPISR  out  8  bit7 SPIF, bit5 SPTEF, bit4 MODF; all other bits 0.
- MRDATA  out  32  {zero-extend, last received word}.
- SCLK  out  1  serial clock.
- MOSI  out  1  serial output.
- SS_n  out  1  slave select, active low.
- spi_irq  out  1  (SPTIE & SPTEF) | MODF.

Behaviour:
- Reset values: SPIF=0, SPTEF=1, MODF=0, MRDATA=0, SCLK=0, MOSI=0, SS_n=1, spi_irq=0, FSM=IDLE, transmit buffer empty.
- Enable condition: active = SPE & MSTR & !MODF.
- When active=0:
  - FSM is forced to IDLE and SS_n=1.
  - SCLK follows CPOL when SPE=1, otherwise SCLK=0.
  - If active falls mid-transfer, the transfer aborts: no SPIF, no MRDATA update, and a pending buffer is discarded (SPTEF=1).
- Transmit buffer:
  - tx_load while SPTEF=1 captures MWDATA[DATA_W-1:0]; SPTEF=0 on the next cycle.
  - tx_load while SPTEF=0 is ignored.
  - tx_load while active=0 is ignored.
- Baud rate:
  - Half-period H = (SPPR+1) << SPR PCLK cycles. H ranges from 1 (SCLK = PCLK/2) to 1024.
  - SPIBDR is latched when leaving IDLE; changes mid-transfer have no effect.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - Enters SETUP on the cycle after the buffer is full and active=1.
  - On entry to SETUP: buffer moves to the shift register, SPTEF=1, SS_n=0.
- SETUP (H cycles):
  - SCLK=CPOL.
  - If CPHA=0, the first bit is driven on MOSI on entry.
- SHIFT (2*DATA_W half-periods, each H cycles): SCLK toggles at the start of each half-period.
  - CPHA=0: sample MISO on odd (leading) edges; drive the next MOSI bit on even (trailing) edges.
  - CPHA=1: drive MOSI on leading edges; sample MISO on trailing edges.
  - Bit order: LSBFE=1 sends and receives LSB first; otherwise MSB first.
- HOLD (H cycles):
  - SCLK=CPOL.
  - On exit: SS_n=1, MRDATA updated, SPIF=1, both in the same cycle.
- GAP (H cycles):
  - SS_n stays high.
  - Then returns to IDLE. Back-to-back transfers therefore always show an SS_n high pulse of at least H cycles.
- Timing totals:
  - SS_n low duration = (2*DATA_W + 2)*H cycles.
  - tx_load to SS_n falling = 2 cycles.
- SPIF:
  - Cleared by data_rd.
  - A set from transfer completion in the same cycle as data_rd wins.
  - Completion while SPIF is already 1 overwrites MRDATA; SPIF stays 1 (no overrun flag).
- MODF:
  - Set when SPE & MSTR & !SSOE & (SS_IN_n==0), sampled every cycle; aborts any transfer.
  - Cleared by status_rd only if SS_IN_n==1 in that cycle.
  - When SSOE=1, SS_IN_n is ignored.
- SPTEF=1 whenever the buffer is empty.

Test Plan:
1. Reset then release, SPIBDR=0x00, SPICR_1=0x50 (SPE, MSTR, CPOL=0, CPHA=0, MSB first), tx_load with MWDATA=0xA5, MISO looped to MOSI -> SS_n low 18 cycles, MOSI pattern 1,0,1,0,0,1,0,1, MRDATA=0x000000A5, SPIF=1, SPTEF=1.
2. SPIBDR=0x21 (SPPR=2, SPR=1, so H=6), CPOL=1, CPHA=1, LSBFE=1, MWDATA=0x01, MISO tied 1 -> SCLK idles high with a 12-cycle period, first MOSI bit is 1, MRDATA=0xFF, SS_n low 108 cycles.
3. Two tx_loads: the second arrives during SHIFT of the first (SPTEF=1 by then), a third tx_load arrives while SPTEF=0 -> exactly two transfers, SS_n high ≥H between them, third value never transmitted.
4. Clear SPE midway through SHIFT -> SS_n=1 next cycle, SPIF stays 0, MRDATA unchanged, SPTEF=1.
5. SSOE=0, drive SS_IN_n=0 mid-transfer -> MODF=1, spi_irq=1, abort; status_rd while SS_IN_n=0 -> MODF stays 1; release SS_IN_n, then status_rd -> MODF=0.
6. data_rd on the exact cycle a second transfer completes -> SPIF remains 1 and MRDATA holds the new word; a later data_rd clears SPIF.

Source files
------------

// File: rtl/spi_shift_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_engine_if
// Description : Register-side bus between the APB SPI register controller
//               and the SPI shift engine.
//               master modport : controller (drives control, data, strobes)
//               slave modport  : shift engine (returns status, read data, irq)
//               Signals:
//                 SPICR_1, SPICR_2, SPIBDR : control and baud registers
//                 MWDATA                   : transmit word
//                 tx_load                  : MWDATA written this cycle
//                 status_rd, data_rd       : SPISR / MRDATA read strobes
//                 SPISR, MRDATA, spi_irq   : status, received word, interrupt
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_shift_engine_if;
  logic [7:0]  SPICR_1;
  logic [7:0]  SPICR_2;
  logic [7:0]  SPIBDR;
  logic [31:0] MWDATA;
  logic        tx_load;
  logic        status_rd;
  logic        data_rd;
  logic [7:0]  SPISR;
  logic [31:0] MRDATA;
  logic        spi_irq;

  modport master (
    output SPICR_1, SPICR_2, SPIBDR, MWDATA, tx_load, status_rd, data_rd,
    input  SPISR, MRDATA, spi_irq
  );

  modport slave (
    input  SPICR_1, SPICR_2, SPIBDR, MWDATA, tx_load, status_rd, data_rd,
    output SPISR, MRDATA, spi_irq
  );
endinterface
`default_nettype wire

// File: rtl/spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_engine
// Description : Master-mode SPI serializer. Single-entry transmit buffer,
//               PCLK-based baud generator and transfer FSM
//               (IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE).
//               Ports:
//                 PCLK, PRESETn : clock, asynchronous active-low reset
//                 bus           : controller register interface (slave side)
//                 MISO, SS_IN_n : serial input, mode-fault sense
//                 SCLK, MOSI    : serial clock and output
//                 SS_n          : slave select, active low
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_engine #(
  parameter int DATA_W = 8
) (
  input  wire               PCLK,
  input  wire               PRESETn,
  spi_shift_engine_if.slave bus,
  input  wire               MISO,
  input  wire               SS_IN_n,
  output logic              SCLK,
  output logic              MOSI,
  output logic              SS_n
);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_SETUP = 3'd1;
  localparam logic [2:0] c_ST_SHIFT = 3'd2;
  localparam logic [2:0] c_ST_HOLD  = 3'd3;
  localparam logic [2:0] c_ST_GAP   = 3'd4;

  // Index of the final SCLK half-period inside SHIFT.
  localparam logic [5:0] c_LAST_EDGE = 6'(2 * DATA_W - 1);

  // Control field decode
  logic w_spe, w_sptie, w_mstr, w_cpol, w_cpha, w_ssoe, w_lsbfe;
  assign w_spe   = bus.SPICR_1[6];
  assign w_sptie = bus.SPICR_1[5];
  assign w_mstr  = bus.SPICR_1[4];
  assign w_cpol  = bus.SPICR_1[3];
  assign w_cpha  = bus.SPICR_1[2];
  assign w_ssoe  = bus.SPICR_1[1];
  assign w_lsbfe = bus.SPICR_1[0];

  // SPC0 is ignored (pins are always unidirectional), as are reserved bits.
  logic w_unused;
  assign w_unused = ^{bus.SPICR_2, bus.SPICR_1[7], bus.SPIBDR[7],
                      bus.SPIBDR[3], bus.MWDATA[31:DATA_W]};

  logic [2:0]        r_state, w_next_state;
  logic [10:0]       r_cnt, r_half, w_half;
  logic [5:0]        r_edge, w_k;
  logic [DATA_W-1:0] r_buf, r_tx, r_rx, r_mrdata;
  logic [DATA_W-1:0] w_tx_src, w_tx_shift;
  logic              r_buf_full, r_mosi, r_spif, r_modf;
  logic              w_active, w_modf_set, w_last, w_tx_bit;
  logic              w_start, w_step, w_drive, w_sample, w_done, w_busy, w_timed;

  assign w_active   = w_spe & w_mstr & ~r_modf;
  assign w_modf_set = w_spe & w_mstr & ~w_ssoe & ~SS_IN_n;

  // Half-period length: (SPPR+1) << SPR, 1..1024 PCLK cycles.
  assign w_half = ({8'd0, bus.SPIBDR[6:4]} + 11'd1) << bus.SPIBDR[2:0];
  assign w_last = (r_cnt == (r_half - 11'd1));

  // Transmit serializer: the first bit comes from the buffer when the
  // transfer starts, later bits from the shift register.
  assign w_tx_src   = w_start ? r_buf : r_tx;
  assign w_tx_bit   = w_lsbfe ? w_tx_src[0] : w_tx_src[DATA_W-1];
  assign w_tx_shift = w_lsbfe ? {1'b0, w_tx_src[DATA_W-1:1]}
                              : {w_tx_src[DATA_W-2:0], 1'b0};

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= c_ST_IDLE;
    else          r_state <= w_next_state;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_next_state = r_state;
    if (!w_active) begin
      w_next_state = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE:  if (r_buf_full) w_next_state = c_ST_SETUP;
        c_ST_SETUP: if (w_last) w_next_state = c_ST_SHIFT;
        c_ST_SHIFT: if (w_last && (r_edge == c_LAST_EDGE)) w_next_state = c_ST_HOLD;
        c_ST_HOLD:  if (w_last) w_next_state = c_ST_GAP;
        c_ST_GAP:   if (w_last) w_next_state = c_ST_IDLE;
        default:    w_next_state = c_ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    w_start  = 1'b0;
    w_step   = 1'b0;
    w_k      = 6'd0;
    w_drive  = 1'b0;
    w_sample = 1'b0;
    w_done   = 1'b0;
    w_busy   = 1'b0;
    w_timed  = 1'b0;
    if (w_active) begin
      case (r_state)
        c_ST_IDLE:  w_start = r_buf_full;
        c_ST_SETUP: begin
          w_busy  = 1'b1;
          w_timed = 1'b1;
          w_step  = w_last;
        end
        c_ST_SHIFT: begin
          w_busy  = 1'b1;
          w_timed = 1'b1;
          w_step  = w_last && (r_edge != c_LAST_EDGE);
          w_k     = r_edge + 6'd1;
        end
        c_ST_HOLD: begin
          w_busy  = 1'b1;
          w_timed = 1'b1;
          w_done  = w_last;
        end
        c_ST_GAP:   w_timed = 1'b1;
        default:    w_timed = 1'b0;
      endcase
    end
    // w_step marks the PCLK edge that opens half-period w_k (an SCLK edge).
    // Even w_k is a leading edge, odd w_k a trailing edge. With CPHA=0 the
    // drive after the last trailing edge is suppressed: no bits remain.
    if (w_step) begin
      if (w_cpha) begin
        w_drive  = ~w_k[0];
        w_sample = w_k[0];
      end else begin
        w_drive  = w_k[0] && (w_k != c_LAST_EDGE);
        w_sample = ~w_k[0];
      end
    end
    SS_n = ~w_busy;
    if (!w_spe)
      SCLK = 1'b0;
    else if (w_active && (r_state == c_ST_SHIFT))
      SCLK = w_cpol ^ ~r_edge[0];
    else
      SCLK = w_cpol;
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt      <= 11'd0;
      r_half     <= 11'd1;
      r_edge     <= 6'd0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_mosi     <= 1'b0;
      r_mrdata   <= '0;
      r_spif     <= 1'b0;
      r_modf     <= 1'b0;
    end else begin
      // Set has priority; a read only clears once the fault input is released.
      r_modf <= w_modf_set | (r_modf & ~(bus.status_rd & SS_IN_n));

      // An inactive engine holds no pending data.
      if (!w_active) begin
        r_buf_full <= 1'b0;
      end else if (w_start) begin
        r_buf_full <= 1'b0;
      end else if (bus.tx_load && !r_buf_full) begin
        r_buf      <= bus.MWDATA[DATA_W-1:0];
        r_buf_full <= 1'b1;
      end

      // Baud timing; SPIBDR is sampled only when a transfer starts.
      if (w_start) begin
        r_half <= w_half;
        r_cnt  <= 11'd0;
        r_edge <= 6'd0;
      end else if (w_timed) begin
        if (w_last) begin
          r_cnt <= 11'd0;
          if (r_state == c_ST_SHIFT) r_edge <= r_edge + 6'd1;
        end else begin
          r_cnt <= r_cnt + 11'd1;
        end
      end

      // Shift registers
      if (w_start) begin
        r_tx <= w_cpha ? r_buf : w_tx_shift;
        r_rx <= '0;
      end else if (w_drive) begin
        r_tx <= w_tx_shift;
      end
      if ((w_start && !w_cpha) || w_drive) r_mosi <= w_tx_bit;
      if (w_sample)
        r_rx <= w_lsbfe ? {MISO, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], MISO};

      // Completion beats a simultaneous data read.
      if (w_done) begin
        r_mrdata <= r_rx;
        r_spif   <= 1'b1;
      end else if (bus.data_rd) begin
        r_spif <= 1'b0;
      end
    end
  end

  assign MOSI        = r_mosi;
  assign bus.SPISR   = {r_spif, 1'b0, ~r_buf_full, r_modf, 4'b0000};
  assign bus.MRDATA  = {{(32-DATA_W){1'b0}}, r_mrdata};
  assign bus.spi_irq = (w_sptie & ~r_buf_full) | r_modf;

endmodule
`default_nettype wire

// File: tb/tb_spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_shift_engine
// Description : Self-checking bench for spi_shift_engine. Stimulus pushes
//               expected transfers into a scoreboard; a monitor watches the
//               SPI pins and checks each transfer when SS_n returns high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_shift_engine;
  localparam int DW = 8;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       SS_IN_n;
  logic       MISO;
  logic       SCLK, MOSI, SS_n;
  logic [1:0] miso_mode;  // 0: loop MOSI, 1: tied high, 2: tied low

  spi_shift_engine_if bus ();

  spi_shift_engine #(.DATA_W(DW)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus),
    .MISO    (MISO),
    .SS_IN_n (SS_IN_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .SS_n    (SS_n)
  );

  always #5 PCLK = ~PCLK;
  assign MISO = (miso_mode == 2'd0) ? MOSI : (miso_mode == 2'd1);

  typedef struct {
    bit          abort;
    bit          exp_spif;
    logic [31:0] mrdata;
    int          low_len;
    logic [15:0] bits;
    bit          cpol;
    bit          cpha;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          exp_falls = 0;
  int          mon_falls = 0;
  int          mon_last_gap = 0;
  logic [31:0] model_mrdata = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // ---------------- reference model
  function automatic int half_of(input logic [7:0] bdr);
    return (int'(bdr[6:4]) + 1) * (2 ** int'(bdr[2:0]));
  endfunction

  function automatic logic [15:0] wire_order(input logic [31:0] d, input bit lsbfe);
    logic [15:0] b = '0;
    for (int i = 0; i < DW; i++) b[i] = lsbfe ? d[i] : d[DW-1-i];
    return b;
  endfunction

  task automatic push_xfer(input logic [31:0] d, input logic [7:0] cr1,
                           input logic [7:0] bdr, input logic [1:0] mode);
    exp_t e;
    logic [31:0] mask = (32'd1 << DW) - 32'd1;
    e.abort    = 1'b0;
    e.exp_spif = 1'b1;
    e.low_len  = (2 * DW + 2) * half_of(bdr);
    e.bits     = wire_order(d, cr1[0]);
    e.cpol     = cr1[3];
    e.cpha     = cr1[2];
    e.mrdata   = (mode == 2'd0) ? (d & mask) : (mode == 2'd1) ? mask : 32'd0;
    model_mrdata = e.mrdata;
    sb.push_back(e);
    exp_falls++;
  endtask

  task automatic push_abort(input logic [7:0] cr1);
    exp_t e;
    e.abort    = 1'b1;
    e.exp_spif = 1'b0;
    e.low_len  = 0;
    e.bits     = '0;
    e.cpol     = cr1[3];
    e.cpha     = cr1[2];
    e.mrdata   = model_mrdata;
    sb.push_back(e);
    exp_falls++;
  endtask

  task automatic load(input logic [31:0] d);
    bus.MWDATA  = d;
    bus.tx_load = 1'b1;
    tick();
    bus.tx_load = 1'b0;
  endtask

  task automatic pulse_data_rd();
    bus.data_rd = 1'b1;
    tick();
    bus.data_rd = 1'b0;
  endtask

  task automatic pulse_status_rd();
    bus.status_rd = 1'b1;
    tick();
    bus.status_rd = 1'b0;
  endtask

  task automatic wait_low(input int budget);
    int n = 0;
    while (SS_n && n < budget) begin
      tick();
      n++;
    end
    chk("ss_fall_timeout", SS_n, 1'b0);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  // ---------------- monitor
  initial begin
    logic        prev_ss = 1'b1;
    logic        prev_sclk = 1'b0;
    int          low = 0, high = 0, edges = 0, nb = 0;
    logic [15:0] got = '0;
    exp_t        cur;
    bit          have = 1'b0;
    bit          odd;
    forever begin
      @(negedge PCLK);
      if (PRESETn) begin
        if (prev_ss && !SS_n) begin
          mon_falls++;
          mon_last_gap = high;
          low   = 1;
          edges = 0;
          nb    = 0;
          got   = '0;
          have  = (sb.size() != 0);
          chk("xfer_expected", have, 1'b1);
          if (have) begin
            cur = sb[0];
            chk("sclk_idle_level", SCLK, cur.cpol);
          end
        end else if (!SS_n) begin
          low++;
          if (SCLK !== prev_sclk) begin
            edges++;
            odd = ((edges % 2) == 1);
            if (have && (odd ^ cur.cpha) && nb < DW) begin
              got[nb] = MOSI;
              nb++;
            end
          end
        end
        if (!prev_ss && SS_n) begin
          high = 1;
          if (have) begin
            void'(sb.pop_front());
            if (cur.abort) begin
              chk("abort_mrdata", bus.MRDATA, cur.mrdata);
              chk("abort_spif", bus.SPISR[7], cur.exp_spif);
            end else begin
              chk("ss_low_len", low, cur.low_len);
              chk("sclk_edges", edges, 2 * DW);
              chk("mosi_bits", got, cur.bits);
              chk("mrdata", bus.MRDATA, cur.mrdata);
              chk("spif_set", bus.SPISR[7], cur.exp_spif);
            end
            have = 1'b0;
          end
        end else if (SS_n) begin
          high++;
        end
      end
      prev_ss   = SS_n;
      prev_sclk = SCLK;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus
  initial begin
    logic [7:0]  cr1, bdr;
    logic [31:0] d;
    logic [1:0]  mode;
    int          h;

    bus.SPICR_1   = 8'h00;
    bus.SPICR_2   = 8'h00;
    bus.SPIBDR    = 8'h00;
    bus.MWDATA    = 32'd0;
    bus.tx_load   = 1'b0;
    bus.status_rd = 1'b0;
    bus.data_rd   = 1'b0;
    SS_IN_n       = 1'b1;
    miso_mode     = 2'd0;

    repeat (3) tick();
    chk("rst_spisr", bus.SPISR, 8'h20);
    chk("rst_mrdata", bus.MRDATA, 32'd0);
    chk("rst_sclk", SCLK, 1'b0);
    chk("rst_mosi", MOSI, 1'b0);
    chk("rst_ss_n", SS_n, 1'b1);
    chk("rst_irq", bus.spi_irq, 1'b0);
    PRESETn = 1'b1;
    tick();

    // 1: H=1, mode 0, MSB first, loopback
    bus.SPIBDR  = 8'h00;
    bus.SPICR_1 = 8'h50;
    tick();
    push_xfer(32'hA5, 8'h50, 8'h00, 2'd0);
    load(32'hA5);
    chk("t1_sptef_full", bus.SPISR[5], 1'b0);
    chk("t1_ss_still_high", SS_n, 1'b1);
    tick();
    chk("t1_ss_fall_at_2", SS_n, 1'b0);
    chk("t1_sptef_moved", bus.SPISR[5], 1'b1);
    wait_drain(100);
    chk("t1_mrdata", bus.MRDATA, 32'h0000_00A5);
    repeat (4) tick();

    // 2: H=6, CPOL=1 CPHA=1 LSB first, MISO tied high
    bus.SPIBDR  = 8'h21;
    bus.SPICR_1 = 8'h5D;
    miso_mode   = 2'd1;
    tick();
    chk("t2_sclk_idle_high", SCLK, 1'b1);
    push_xfer(32'h01, 8'h5D, 8'h21, 2'd1);
    load(32'h01);
    wait_drain(300);
    chk("t2_mrdata", bus.MRDATA, 32'h0000_00FF);
    repeat (10) tick();

    // 3: back-to-back; third load while buffer full is dropped
    bus.SPIBDR  = 8'h00;
    bus.SPICR_1 = 8'h50;
    miso_mode   = 2'd0;
    tick();
    push_xfer(32'h3C, 8'h50, 8'h00, 2'd0);
    load(32'h3C);
    wait_low(10);
    repeat (3) tick();
    chk("t3_sptef_in_shift", bus.SPISR[5], 1'b1);
    push_xfer(32'h96, 8'h50, 8'h00, 2'd0);
    load(32'h96);
    chk("t3_sptef_full", bus.SPISR[5], 1'b0);
    load(32'h7E);
    wait_drain(200);
    chk("t3_gap_ge_h", 32'(mon_last_gap >= 1), 32'd1);
    repeat (40) tick();
    chk("t3_xfer_count", mon_falls, exp_falls);

    // 4: SPE cleared mid-SHIFT with a pending buffer
    pulse_data_rd();
    chk("t4_spif_cleared", bus.SPISR[7], 1'b0);
    push_abort(8'h50);
    load(32'h5A);
    wait_low(10);
    repeat (3) tick();
    load(32'hC7);
    bus.SPICR_1 = 8'h10;
    tick();
    chk("t4_ss_high", SS_n, 1'b1);
    chk("t4_spif", bus.SPISR[7], 1'b0);
    chk("t4_mrdata", bus.MRDATA, model_mrdata);
    chk("t4_sptef", bus.SPISR[5], 1'b1);
    chk("t4_sclk_spe0", SCLK, 1'b0);
    bus.SPICR_1 = 8'h48;
    tick();
    chk("t4_sclk_follow_cpol", SCLK, 1'b1);
    bus.SPICR_1 = 8'h50;
    repeat (40) tick();
    chk("t4_xfer_count", mon_falls, exp_falls);

    // 5: mode fault
    push_abort(8'h50);
    load(32'hE1);
    wait_low(10);
    repeat (3) tick();
    SS_IN_n = 1'b0;
    tick();
    chk("t5_modf_set", bus.SPISR[4], 1'b1);
    chk("t5_irq", bus.spi_irq, 1'b1);
    chk("t5_ss_abort", SS_n, 1'b1);
    pulse_status_rd();
    chk("t5_modf_held", bus.SPISR[4], 1'b1);
    SS_IN_n = 1'b1;
    tick();
    pulse_status_rd();
    chk("t5_modf_clear", bus.SPISR[4], 1'b0);
    bus.SPICR_1 = 8'h52;
    SS_IN_n = 1'b0;
    repeat (2) tick();
    chk("t5_ssoe_ignores", bus.SPISR[4], 1'b0);
    SS_IN_n = 1'b1;
    bus.SPICR_1 = 8'h70;
    tick();
    chk("t5_sptie_irq", bus.spi_irq, 1'b1);
    bus.SPICR_1 = 8'h50;
    tick();
    chk("t5_xfer_count", mon_falls, exp_falls);

    // 6: data_rd on the completion cycle
    push_xfer(32'h3C, 8'h50, 8'h00, 2'd0);
    load(32'h3C);
    wait_drain(100);
    repeat (4) tick();
    push_xfer(32'hC3, 8'h50, 8'h00, 2'd0);
    load(32'hC3);
    tick();
    repeat (17) tick();
    bus.data_rd = 1'b1;
    tick();
    bus.data_rd = 1'b0;
    chk("t6_spif_wins", bus.SPISR[7], 1'b1);
    chk("t6_mrdata_new", bus.MRDATA, 32'h0000_00C3);
    pulse_data_rd();
    chk("t6_spif_cleared", bus.SPISR[7], 1'b0);
    wait_drain(20);
    repeat (4) tick();

    // Randomized transfers; SPIBDR is scrambled mid-transfer
    for (int it = 0; it < 24; it++) begin
      cr1  = 8'h50 | {4'd0, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom)};
      bdr  = {1'b0, 3'($urandom_range(0, 2)), 1'b0, 3'($urandom_range(0, 2))};
      mode = 2'($urandom_range(0, 2));
      d    = 32'($urandom);
      h    = half_of(bdr);
      bus.SPICR_1 = cr1;
      bus.SPIBDR  = bdr;
      miso_mode   = mode;
      repeat (2) tick();
      push_xfer(d, cr1, bdr, mode);
      load(d);
      wait_low(10);
      bus.SPIBDR = 8'($urandom) & 8'h77;
      wait_drain((2 * DW + 2) * h + 20);
      repeat (h + 3) tick();
    end

    chk("final_sb_empty", sb.size(), 0);
    chk("final_xfer_count", mon_falls, exp_falls);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
